// File: rtl/fp_lane_dispatcher.sv
// Round-robin dispatch of paired a/b operands to LANES identical units, with
// results retired strictly in issue order onto a single output_z stream.
module fp_lane_dispatcher #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LANES = 4,
   parameter int unsigned CW    = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       input_a,
   input  logic                   input_a_stb,
   output logic                   input_a_ack,
   input  logic [WIDTH-1:0]       input_b,
   input  logic                   input_b_stb,
   output logic                   input_b_ack,
   output logic [LANES*WIDTH-1:0] lane_a,
   output logic [LANES*WIDTH-1:0] lane_b,
   output logic [LANES-1:0]       lane_stb,
   input  logic [LANES-1:0]       lane_ack,
   input  logic [LANES*WIDTH-1:0] lane_z,
   input  logic [LANES-1:0]       lane_z_stb,
   output logic [LANES-1:0]       lane_z_ack,
   output logic [WIDTH-1:0]       output_z,
   output logic                   output_z_stb,
   input  logic                   output_z_ack,
   output logic [CW-1:0]          in_flight
);

   localparam int unsigned PW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [PW-1:0] LastLane = PW'(LANES - 1);

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic             a_valid_q, a_valid_d;
   logic             b_valid_q, b_valid_d;
   logic             z_valid_q, z_valid_d;
   logic [LANES-1:0] busy_q, busy_d;
   logic [PW-1:0]    issue_ptr_q, issue_ptr_d;
   logic [PW-1:0]    retire_ptr_q, retire_ptr_d;
   logic [CW-1:0]    in_flight_q, in_flight_d;

   logic             a_fire, b_fire, out_fire;
   logic             pair_ready;
   logic             issue_busy, issue_ack, issue_fire;
   logic             retire_busy, retire_stb, retire_fire;
   logic [WIDTH-1:0] retire_z;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == LastLane) ? '0 : p + 1'b1;
   endfunction

   // Acks are forced low while reset is held, even though the valid flags are clear.
   assign input_a_ack  = ~a_valid_q & ~rst;
   assign input_b_ack  = ~b_valid_q & ~rst;
   assign a_fire       = input_a_stb & input_a_ack;
   assign b_fire       = input_b_stb & input_b_ack;
   assign out_fire     = z_valid_q & output_z_ack;
   assign pair_ready   = a_valid_q & b_valid_q;

   assign lane_a       = {LANES{a_q}};
   assign lane_b       = {LANES{b_q}};
   assign output_z     = z_q;
   assign output_z_stb = z_valid_q;
   assign in_flight    = in_flight_q;

   // Pick out the handshake signals of the lanes addressed by the two pointers.
   always_comb begin
      issue_busy  = 1'b0;
      issue_ack   = 1'b0;
      retire_busy = 1'b0;
      retire_stb  = 1'b0;
      retire_z    = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (issue_ptr_q == PW'(i)) begin
            issue_busy = busy_q[i];
            issue_ack  = lane_ack[i];
         end
         if (retire_ptr_q == PW'(i)) begin
            retire_busy = busy_q[i];
            retire_stb  = lane_z_stb[i];
            retire_z    = lane_z[i*WIDTH +: WIDTH];
         end
      end
   end

   assign issue_fire  = pair_ready & ~issue_busy & issue_ack;
   assign retire_fire = retire_busy & ~z_valid_q & retire_stb;

   always_comb begin
      lane_stb   = '0;
      lane_z_ack = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         lane_stb[i]   = (issue_ptr_q == PW'(i)) & pair_ready & ~busy_q[i];
         lane_z_ack[i] = (retire_ptr_q == PW'(i)) & busy_q[i] & ~z_valid_q;
      end
   end

   always_comb begin
      busy_d = busy_q;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (issue_fire && (issue_ptr_q == PW'(i))) begin
            busy_d[i] = 1'b1;
         end
         if (retire_fire && (retire_ptr_q == PW'(i))) begin
            busy_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      a_d          = a_q;
      b_d          = b_q;
      z_d          = z_q;
      a_valid_d    = a_valid_q;
      b_valid_d    = b_valid_q;
      z_valid_d    = z_valid_q;
      issue_ptr_d  = issue_ptr_q;
      retire_ptr_d = retire_ptr_q;
      in_flight_d  = in_flight_q + CW'(issue_fire) - CW'(retire_fire);

      // Capture requires an empty holding register and issue requires a full one,
      // so the two never collide on the same cycle.
      if (a_fire) begin
         a_d       = input_a;
         a_valid_d = 1'b1;
      end
      if (b_fire) begin
         b_d       = input_b;
         b_valid_d = 1'b1;
      end
      if (issue_fire) begin
         a_valid_d   = 1'b0;
         b_valid_d   = 1'b0;
         issue_ptr_d = wrap_inc(issue_ptr_q);
      end

      if (retire_fire) begin
         z_d          = retire_z;
         z_valid_d    = 1'b1;
         retire_ptr_d = wrap_inc(retire_ptr_q);
      end else if (out_fire) begin
         z_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q          <= '0;
         b_q          <= '0;
         z_q          <= '0;
         a_valid_q    <= 1'b0;
         b_valid_q    <= 1'b0;
         z_valid_q    <= 1'b0;
         busy_q       <= '0;
         issue_ptr_q  <= '0;
         retire_ptr_q <= '0;
         in_flight_q  <= '0;
      end else begin
         a_q          <= a_d;
         b_q          <= b_d;
         z_q          <= z_d;
         a_valid_q    <= a_valid_d;
         b_valid_q    <= b_valid_d;
         z_valid_q    <= z_valid_d;
         busy_q       <= busy_d;
         issue_ptr_q  <= issue_ptr_d;
         retire_ptr_q <= retire_ptr_d;
         in_flight_q  <= in_flight_d;
      end
   end

endmodule

// File: doc/fp_lane_dispatcher.md
Name: fp_lane_dispatcher

Overview:
- Parametrised successor to the single-unit operand harness.
- Accepts paired operand streams a/b over stb/ack and dispatches each pair round-robin to LANES identical arithmetic units (e.g. divider instances).
- Collects the lane results and re-emits them as one in-order output_z stream.
- Sits between file readers/producers and N parallel FP units, so throughput scales with lane count while result ordering is preserved.

Parameters:
WIDTH, 16, operand/result width in bits
LANES, 4, number of attached units; legal range 1..16
CW, 5, width of in_flight count; must be at least clog2(LANES+1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
input_a  in  WIDTH  operand a
input_a_stb  in  1  operand a valid
input_a_ack  out  1  operand a accepted
input_b  in  WIDTH  operand b
input_b_stb  in  1  operand b valid
input_b_ack  out  1  operand b accepted
lane_a  out  LANES*WIDTH  operand a to each lane; lane i uses bits [i*WIDTH +: WIDTH]
lane_b  out  LANES*WIDTH  operand b to each lane
lane_stb  out  LANES  operand pair valid, one bit per lane
lane_ack  in  LANES  lane accepted its operand pair
lane_z  in  LANES*WIDTH  lane results
lane_z_stb  in  LANES  lane result valid
lane_z_ack  out  LANES  lane result taken
output_z  out  WIDTH  merged in-order result
output_z_stb  out  1  result valid
output_z_ack  in  1  downstream accepted the result
in_flight  out  CW  number of lanes currently busy

Behaviour:
- Transfer rule: data moves on any cycle where stb and ack are both high at the rising edge. The receiver may raise ack independently of stb.
- Reset: asynchronous and active-high.
  - Clears a_valid, b_valid, z_valid, busy[LANES-1:0], issue_ptr, retire_ptr and in_flight.
  - All stb/ack outputs go low. output_z, lane_a and lane_b are 0.
  - Reset mid-operation discards held operands and the pending result. Lanes are not notified.
- Operand capture:
  - input_a_ack = !a_valid. A transfer loads the a register and sets a_valid.
  - Operand b is handled identically and independently, so a and b may arrive in different cycles.
- Issue:
  - lane_stb[issue_ptr] = a_valid & b_valid & !busy[issue_ptr]. All other lane_stb bits are 0.
  - lane_a/lane_b carry the held registers on every lane slice.
  - On lane_ack[issue_ptr] & lane_stb[issue_ptr]:
    - clear a_valid and b_valid;
    - set busy[issue_ptr];
    - issue_ptr = (issue_ptr == LANES-1) ? 0 : issue_ptr+1.
  - Minimum latency from the input transfer edge to lane_stb high is 1 cycle.
  - While lane_stb is high, operands stay stable until the lane acks.
- Retire:
  - lane_z_ack[retire_ptr] = busy[retire_ptr] & !z_valid. All other bits are 0.
  - A lane that finishes out of turn holds its result until it becomes retire_ptr. This guarantees output order equals issue order.
  - On transfer: load output_z, set z_valid, clear busy[retire_ptr], and advance retire_ptr with wrap.
  - output_z_stb = z_valid. z_valid clears on output_z_ack.
  - Back-to-back retire is impossible, so peak output rate is one result per 2 cycles; this is accepted.
- in_flight = popcount(busy), registered.
  - Issue and retire in the same cycle leave it unchanged.
  - With LANES=1, issue requires !busy and retire requires busy, so both cannot hit the same lane in one cycle.
- Full condition: all lanes busy, so a_valid & b_valid stay set and input acks stay low. Backpressure reaches the producers.
- Empty condition: in_flight=0 and no pending operands or result. All strobes are low.
- Pointer wrap: pointers are modulo LANES and must be correct for non-power-of-two LANES (e.g. 3).

Test Plan:
1. Reset, then a=16'h3C00, b=16'h4000, LANES=4, lane 0 returns 16'h3800 after 10 cycles -> lane_stb[0] high 1 cycle after input transfer; output_z=16'h3800 with stb; in_flight goes 0→1→0.
2. 6 pairs back-to-back; each lane answers after a fixed 20 cycles -> lanes 0,1,2,3 issued, 5th pair stalls (input acks low, in_flight=4) until lane 0 retires; 5th and 6th issue to lanes 0 and 1; outputs in issue order.
3. Lane latencies 30/5/5/5 cycles for pairs 0..3 -> lanes 1–3 hold lane_z_stb unacked until lane 0 retires; output order is pair 0,1,2,3.
4. Operand a arrives 7 cycles before b -> input_a_ack low after capture; issue occurs 1 cycle after the b transfer; a value is unchanged.
5. output_z_ack held low for 15 cycles with results pending -> output_z stable, lane_z_ack stays low, no result lost; resuming drains all results in order.
6. Assert rst while 3 lanes are busy and output_z_stb is high -> all strobes and acks low immediately (async), in_flight=0, ptrs=0; with LANES=3, wrap 2→0 verified over 9 pairs.
